// File: rtl/selector_32.sv
// Next-PC selector: combinational a/b mux for the PC register, plus registered
// observation outputs (selection copy, select history, saturating branch count).
module selector_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             s_q,
    output logic [CNT_W-1:0] b_count,
    output logic             sel_toggle
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // The PC register samples this path directly, so it stays unregistered
    // and is independent of reset. There is no handshake: every edge samples.
    assign out = s ? b : a;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q      <= '0;
            s_q        <= 1'b0;
            sel_toggle <= 1'b0;
            b_count    <= '0;
        end else begin
            out_q      <= out;
            s_q        <= s;
            sel_toggle <= (s != s_q);
            // Saturate rather than wrap so a long branch run never reads as few.
            if (s && (b_count != CNT_MAX)) begin
                b_count <= b_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_selector_32.sv
// Randomized bench for selector_32 against a behavioural reference model.
module tb_selector_32;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] out;
    logic [31:0] out_q;
    logic        s_q;
    logic [15:0] b_count;
    logic        sel_toggle;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    int          m_cnt;
    bit          m_s_q;
    bit          m_tog;

    selector_32 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .s          (s),
        .out        (out),
        .out_q      (out_q),
        .s_q        (s_q),
        .b_count    (b_count),
        .sel_toggle (sel_toggle)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Driver: apply inputs and check the combinational path with no clock edge.
    task automatic drive(input logic [31:0] na, input logic [31:0] nb, input logic ns);
        a = na;
        b = nb;
        s = ns;
        #1;
        check("out", out, ns ? nb : na);
    endtask

    // One clock edge: update the model from the sampled inputs, then check
    // every registered output shortly after the edge.
    task automatic tick();
        logic [31:0] exp_out_q;
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            exp_q.push_back(32'h0);
            m_s_q = 1'b0;
            m_tog = 1'b0;
            m_cnt = 0;
        end else begin
            exp_q.push_back(s ? b : a);
            m_tog = (s != m_s_q);
            m_s_q = s;
            if (s && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
        #1;
        exp_out_q = exp_q.pop_front();
        check("out_q", out_q, exp_out_q);
        check("s_q", 32'(s_q), 32'(m_s_q));
        check("sel_toggle", 32'(sel_toggle), 32'(m_tog));
        check("b_count", 32'(b_count), 32'(m_cnt));
    endtask

    initial begin
        m_cnt = 0;
        m_s_q = 1'b0;
        m_tog = 1'b0;
        rst_n = 1'b0;
        a = '0;
        b = '0;
        s = 1'b0;

        // Combinational select with no clock edge
        drive(32'h8, 32'h10, 1'b0);
        check("out_a_const", out, 32'h8);
        drive(32'h8, 32'h10, 1'b1);
        check("out_b_const", out, 32'h10);

        // Two reset edges with s=1: registers clear, out still follows b
        tick();
        tick();
        check("rst_out_q", out_q, 32'h0);
        check("rst_b_count", 32'(b_count), 32'h0);
        check("rst_s_q", 32'(s_q), 32'h0);
        check("rst_out_is_b", out, 32'h10);

        // s=1 for three edges then 0 for two
        rst_n = 1'b1;
        tick();
        check("tog_edge1", 32'(sel_toggle), 32'h1);
        check("s_q_edge1", 32'(s_q), 32'h1);
        tick();
        check("tog_edge2", 32'(sel_toggle), 32'h0);
        tick();
        check("cnt_after3", 32'(b_count), 32'h3);
        drive(32'h8, 32'h10, 1'b0);
        tick();
        check("tog_edge4", 32'(sel_toggle), 32'h1);
        check("s_q_edge4", 32'(s_q), 32'h0);
        tick();
        check("tog_edge5", 32'(sel_toggle), 32'h0);
        check("cnt_after5", 32'(b_count), 32'h3);

        // Saturation: long run of s=1 must stop at all-ones
        drive(32'h8, 32'h10, 1'b1);
        repeat (65540) tick();
        check("cnt_sat", 32'(b_count), 32'h0000_FFFF);
        tick();
        check("cnt_hold", 32'(b_count), 32'h0000_FFFF);

        // Single reset edge mid-stream
        rst_n = 1'b0;
        tick();
        check("mid_rst_out_q", out_q, 32'h0);
        check("mid_rst_cnt", 32'(b_count), 32'h0);
        rst_n = 1'b1;

        // Random stream with one more reset pulse partway through
        for (int i = 0; i < 1000; i++) begin
            drive($urandom, $urandom, 1'($urandom_range(0, 1)));
            rst_n = (i == 500) ? 1'b0 : 1'b1;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
